// File: rtl/mult_seq_ctrl_if.sv
// Handshake bundle between the multiplier sequencing controller and its
// surroundings: debounced buttons and multiplier status in, strobes and
// display/status flags out.
interface mult_seq_ctrl_if;
  logic       btn_c;
  logic       btn_l;
  logic       btn_r;
  logic       mult_done;
  logic       load;
  logic [1:0] sel;
  logic       busy;
  logic       result_valid;
  logic       timeout_err;

  // Side that drives the buttons and reports multiplier completion.
  modport master (
    output btn_c, btn_l, btn_r, mult_done,
    input  load, sel, busy, result_valid, timeout_err
  );

  // The controller itself.
  modport slave (
    input  btn_c, btn_l, btn_r, mult_done,
    output load, sel, busy, result_valid, timeout_err
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for a multi-cycle multiplier: starts an operation on
// the centre button, waits for completion with a timeout, then lets the user
// scroll a three-digit window across the BCD product.
module mult_seq_ctrl #(
  parameter int TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_seq_ctrl_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    SHOW
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             load_q, load_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             result_valid_q, result_valid_d;
  logic             timeout_err_q, timeout_err_d;

  assign bus.load         = load_q;
  assign bus.sel          = sel_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.timeout_err  = timeout_err_q;

  // Next-state and next-output decode; outputs are computed for the state
  // being entered so every output comes straight from a flop.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    load_d         = 1'b0;
    sel_d          = sel_q;
    busy_d         = busy_q;
    result_valid_d = result_valid_q;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (bus.btn_c) begin
          state_d        = LOAD;
          load_d         = 1'b1;
          busy_d         = 1'b1;
          result_valid_d = 1'b0;
          timeout_err_d  = 1'b0;
          sel_d          = 2'd0;
        end
      end

      LOAD: begin
        state_d    = WAIT;
        busy_d     = 1'b1;
        wait_cnt_d = '0;
      end

      WAIT: begin
        busy_d = 1'b1;
        // A done seen in the very first wait cycle may be left over from the
        // previous product, so it only counts from the second cycle on.
        if (bus.mult_done && (wait_cnt_q != '0)) begin
          state_d        = SHOW;
          busy_d         = 1'b0;
          result_valid_d = 1'b1;
        end else if (wait_cnt_q == CNT_MAX) begin
          state_d       = IDLE;
          busy_d        = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      SHOW: begin
        if (bus.btn_c) begin
          state_d        = LOAD;
          load_d         = 1'b1;
          busy_d         = 1'b1;
          result_valid_d = 1'b0;
          timeout_err_d  = 1'b0;
          sel_d          = 2'd0;
        end else if (bus.btn_l && !bus.btn_r && (sel_q != 2'd2)) begin
          sel_d = sel_q + 2'd1;
        end else if (bus.btn_r && !bus.btn_l && (sel_q != 2'd0)) begin
          sel_d = sel_q - 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      load_q         <= 1'b0;
      sel_q          <= 2'd0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      load_q         <= load_d;
      sel_q          <= sel_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios followed by
// randomized button/done traffic, all compared against a behavioural model.
module tb_mult_seq_ctrl;

  localparam int TO = 32;

  logic clk;
  logic rst_n;

  mult_seq_ctrl_if bus ();

  mult_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nChecks = 0;
  int nErrors = 0;

  // Behavioural model: opAge is -1 when no operation is in flight, 0 in the
  // cycle the load strobe is out, and k>=1 in the k-th cycle of waiting.
  int opAge;
  bit shown;
  int window;
  bit errFlag;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    opAge   = -1;
    shown   = 1'b0;
    window  = 0;
    errFlag = 1'b0;
  endtask

  task automatic modelStep(input bit c, input bit l, input bit r, input bit d);
    int waitedBefore;
    if (shown) begin
      if (c) begin
        shown   = 1'b0;
        opAge   = 0;
        window  = 0;
        errFlag = 1'b0;
      end else if (l && !r) begin
        window = (window + 1 > 2) ? 2 : window + 1;
      end else if (r && !l) begin
        window = (window - 1 < 0) ? 0 : window - 1;
      end
    end else if (opAge < 0) begin
      if (c) begin
        opAge   = 0;
        window  = 0;
        errFlag = 1'b0;
      end
    end else if (opAge == 0) begin
      opAge = 1;
    end else begin
      waitedBefore = opAge - 1;
      if (d && waitedBefore >= 1) begin
        opAge = -1;
        shown = 1'b1;
      end else if (waitedBefore == TO - 1) begin
        opAge   = -1;
        errFlag = 1'b1;
      end else begin
        opAge++;
      end
    end
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".load"},         int'(bus.load),         (opAge == 0) ? 1 : 0);
    checkOutput({where, ".busy"},         int'(bus.busy),         (opAge >= 0) ? 1 : 0);
    checkOutput({where, ".result_valid"}, int'(bus.result_valid), shown ? 1 : 0);
    checkOutput({where, ".sel"},          int'(bus.sel),          window);
    checkOutput({where, ".timeout_err"},  int'(bus.timeout_err),  errFlag ? 1 : 0);
  endtask

  // Drive one cycle of inputs from a falling edge, advance the model on the
  // rising edge, then compare outputs on the next falling edge.
  task automatic applyStimulus(input bit c, input bit l, input bit r, input bit d, input string where);
    bus.btn_c     = c;
    bus.btn_l     = l;
    bus.btn_r     = r;
    bus.mult_done = d;
    @(posedge clk);
    modelStep(c, l, r, d);
    @(negedge clk);
    checkAll(where);
  endtask

  bit doneLevel;

  initial begin
    rst_n         = 1'b0;
    bus.btn_c     = 1'b0;
    bus.btn_l     = 1'b0;
    bus.btn_r     = 1'b0;
    bus.mult_done = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;

    // Nominal: start, done rises 8 cycles after load, then drops.
    applyStimulus(1, 0, 0, 0, "nom_start");
    checkOutput("nom_load_pulse", int'(bus.load), 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, "nom_wait");
    applyStimulus(0, 0, 0, 1, "nom_done");
    checkOutput("nom_show_rv", int'(bus.result_valid), 1);
    checkOutput("nom_show_busy", int'(bus.busy), 0);
    applyStimulus(0, 0, 0, 0, "nom_hold");

    // Scrolling in SHOW.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, "scroll_l");
    applyStimulus(0, 1, 1, 0, "scroll_both");
    checkOutput("scroll_both_sel", int'(bus.sel), 2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, "scroll_r");
    checkOutput("scroll_r_sel", int'(bus.sel), 0);

    // Restart priority from sel=2.
    applyStimulus(0, 1, 0, 0, "prio_up");
    applyStimulus(0, 1, 0, 0, "prio_up");
    applyStimulus(1, 1, 0, 0, "prio_restart");
    checkOutput("prio_sel", int'(bus.sel), 0);
    checkOutput("prio_load", int'(bus.load), 1);

    // Stale done held high across the load.
    applyStimulus(0, 0, 0, 1, "stale_wait0");
    checkOutput("stale_not_taken", int'(bus.result_valid), 0);
    applyStimulus(0, 0, 0, 1, "stale_wait1");
    applyStimulus(0, 0, 0, 1, "stale_show");
    checkOutput("stale_show_rv", int'(bus.result_valid), 1);

    // Timeout with done held low, then restart clears the error.
    applyStimulus(1, 0, 0, 0, "to_start");
    for (int i = 0; i < TO + 4; i++) applyStimulus(0, 1, 1, 0, "to_wait");
    checkOutput("to_err", int'(bus.timeout_err), 1);
    applyStimulus(1, 0, 0, 0, "to_restart");
    checkOutput("to_err_cleared", int'(bus.timeout_err), 0);

    // Done arriving in the very last wait cycle beats the timeout.
    applyStimulus(0, 0, 0, 0, "edge_load");
    for (int i = 0; i < TO - 1; i++) applyStimulus(0, 0, 0, 0, "edge_wait");
    applyStimulus(0, 0, 0, 1, "edge_done");
    checkOutput("edge_rv", int'(bus.result_valid), 1);
    checkOutput("edge_err", int'(bus.timeout_err), 0);

    // Asynchronous reset between edges in the middle of WAIT.
    applyStimulus(1, 0, 0, 0, "ar_start");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, "ar_wait");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("ar_immediate");
    @(negedge clk);
    checkAll("ar_held");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, "ar_after");
    applyStimulus(1, 0, 0, 0, "ar_first_start");
    checkOutput("ar_first_load", int'(bus.load), 1);

    // Randomized traffic.
    doneLevel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) doneLevel = ~doneLevel;
      applyStimulus(($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0),
                    doneLevel, "rand");
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
